reg_drain: RTL and testbench
============================

// Module: reg_drain
// PURPOSE
//  Parallel-in/serial-out unloader, the read side of the push-shift register bank.
//  Snapshots the full DEPTH-word bank in one cycle, then streams the words out one per
//  accepted valid/ready beat, oldest (index DEPTH-1) first.
//  Sits between the register bank and any serial consumer (UART tx, checker, FIFO).
// PARAMETERS
//  WIDTH  32  bits per word
//  DEPTH  32  words per snapshot (>=1)
// PORTS
//  clk_i    in   1              single clock, rising edge
//  rst_i    in   1              synchronous, active-low reset (asserted when 0)
//  load_i   in   1              snapshot request
//  data_i   in   DEPTH*WIDTH    packed [DEPTH-1:0][WIDTH-1:0]; word 0 newest, DEPTH-1 oldest
//  flush_i  in   1              abort drain, discard remaining words
//  ready_i  in   1              consumer accepts data_o this cycle
//  valid_o  out  1              data_o holds a word
//  data_o   out  WIDTH          current word
//  cnt_o    out  $clog2(DEPTH+1) words remaining, including the current one
//  busy_o   out  1              state != IDLE
//  done_o   out  1              1-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (rst_i==0 at edge): state=IDLE, buffer=0, cnt=0, valid_o=0, data_o=0,
//    busy_o=0, done_o=0. Overrides every other input; a drain is lost mid-operation.
//  - FSM IDLE -> DRAIN -> IDLE, enum typedef in package.
//  - IDLE: load_i=1 at edge N -> buffer<=data_i, cnt<=DEPTH, state<=DRAIN.
//    valid_o=1 from cycle N+1 (1-cycle latency). data_o = buffer[DEPTH-1].
//  - DRAIN: beat = valid_o & ready_i. On beat, buffer[k]<=buffer[k-1] for k>=1,
//    buffer[0]<=0, cnt<=cnt-1.
//  - Beat with cnt==1 -> state<=IDLE, valid_o<=0, done_o=1 for exactly the next cycle.
//  - valid_o & !ready_i: data_o, cnt_o and buffer hold (no drop, no dup).
//  - load_i is ignored outside IDLE, including on the final-beat cycle.
//    A load in the first IDLE cycle (same cycle done_o is high) is accepted.
//  - flush_i in DRAIN: state<=IDLE, buffer<=0, cnt<=0, valid_o<=0, no done_o pulse.
//    flush_i in IDLE: no effect. Priority: reset > flush > beat.
//  - cnt_o == 0 iff IDLE. DEPTH==1: single beat, then done_o.
//  - Outputs are registered, with no combinational path from ready_i to valid_o or data_o.
// CONFIGURATION
//  REG_DRAIN_PARITY_EN defined: extra output par_o (1 bit) = ^data_o (even parity),
//    registered alongside data_o, 0 at reset and when valid_o==0.
//  Not defined: no par_o port. Behaviour is otherwise identical.
// STRUCTURE
//  Package reg_pkg: typedef enum logic {IDLE, DRAIN} drain_state_t;
//    localparam CNT_W = $clog2(DEPTH+1) derived in module (parameter-dependent).
//  Sub-module reg_drain_word: one WIDTH-bit stage with sync active-low reset and
//    a load/shift/hold mux. Instantiated DEPTH times in a generate loop.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  1 Reset: rst_i=0 for 2 cycles with load_i=1 -> all outputs 0, busy_o=0.
//  2 Load data_i={8'h44,8'h33,8'h22,8'h11}, ready_i=1 -> data_o 44,33,22,11 on
//    4 consecutive cycles; done_o one cycle later; cnt_o 4,3,2,1,0.
//  3 Same load, ready_i toggles 1,0,0,1,... -> data_o holds during stalls, no word
//    lost or repeated, exactly 4 beats.
//  4 Load during DRAIN with new data 8'hAA.. -> ignored; original 4 words drained.
//    Load on the done_o cycle -> accepted.
//  5 flush_i after 2 beats -> valid_o=0, cnt_o=0, no done_o. Then rst_i=0 mid-drain
//    -> IDLE with all outputs 0.
//  6 DEPTH=1, load 8'h5A -> one beat 5A, done_o. With REG_DRAIN_PARITY_EN: par_o=0
//    for 5A, 1 for 8'h01.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types for the reg_drain parallel-in/serial-out unloader.
package reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/reg_drain_word.sv
// One WIDTH-bit buffer stage of the unloader.
// Priority per edge: reset, then clear, then parallel load, then shift-in, else hold.
module reg_drain_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] shift_data,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every stage samples its
    // neighbour's pre-edge value; blocking here would ripple a word through the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shift_data;
        end
    end

endmodule

// File: rtl/reg_drain.sv
// Snapshot-and-stream unloader: captures DEPTH words, emits oldest first on valid/ready.
// Optional feature macro: REG_DRAIN_PARITY_EN adds the registered even-parity output par_o.
module reg_drain
    import reg_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
    input  logic                        flush_i,
    input  logic                        ready_i,
    output logic                        valid_o,
    output logic [WIDTH-1:0]            data_o,
    output logic [CNT_W-1:0]            cnt_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef REG_DRAIN_PARITY_EN
    ,
    output logic                        par_o
`endif
);

    drain_state_t                state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;
    logic                        load_en, shift_en, clear_en;
    logic                        beat;
    logic [DEPTH-1:0][WIDTH-1:0] buffer;
    logic [DEPTH-1:0][WIDTH-1:0] shift_src;

    assign beat = valid_q & ready_i;

    // Word k takes word k-1 on a beat; word 0 refills with zeros so a drained bank reads 0.
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        if (k == 0) begin : g_head
            assign shift_src[k] = '0;
        end else begin : g_body
            assign shift_src[k] = buffer[k-1];
        end

        // NOTE: the snapshot buffer is reset along with the control state, so
        // data_o reads 0 after reset instead of stale bank contents.
        reg_drain_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk       (clk_i),
            .rst_n     (rst_i),
            .clear     (clear_en),
            .load      (load_en),
            .shift     (shift_en),
            .load_data (data_i[k]),
            .shift_data(shift_src[k]),
            .q         (buffer[k])
        );
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        clear_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    load_en = 1'b1;
                    cnt_d   = CNT_W'(DEPTH);
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    clear_en = 1'b1;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end else if (beat) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef REG_DRAIN_PARITY_EN
    logic [WIDTH-1:0] top_d;
    logic             par_q;

    // Predict the next head word so parity lands in the same cycle as data_o.
    always_comb begin
        top_d = buffer[DEPTH-1];
        if (load_en) begin
            top_d = data_i[DEPTH-1];
        end else if (clear_en) begin
            top_d = '0;
        end else if (shift_en) begin
            top_d = shift_src[DEPTH-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= valid_d & (^top_d);
        end
    end

    assign par_o = par_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = buffer[DEPTH-1];
    assign cnt_o   = cnt_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;

endmodule

// File: tb/tb_reg_drain.sv
// Scoreboard bench for reg_drain (WIDTH=8, DEPTH=4) plus a directed DEPTH=1 instance.
module tb_reg_drain;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_i   = 1'b0;
    logic                load_i  = 1'b0;
    logic                flush_i = 1'b0;
    logic                ready_i = 1'b0;
    logic [D-1:0][W-1:0] data_i  = '0;
    logic                valid_o, busy_o, done_o;
    logic [W-1:0]        data_o;
    logic [CW-1:0]       cnt_o;

    logic                load1  = 1'b0;
    logic                ready1 = 1'b0;
    logic [0:0][W-1:0]   data1  = '0;
    logic                valid1, busy1, done1;
    logic [W-1:0]        dout1;
    logic [0:0]          cnt1;

`ifdef REG_DRAIN_PARITY_EN
    logic par_o, par1;
`endif

    reg_drain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .load_i (load_i),
        .data_i (data_i),
        .flush_i(flush_i),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .data_o (data_o),
        .cnt_o  (cnt_o),
        .busy_o (busy_o),
        .done_o (done_o)
`ifdef REG_DRAIN_PARITY_EN
        ,
        .par_o  (par_o)
`endif
    );

    reg_drain #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .load_i (load1),
        .data_i (data1),
        .flush_i(1'b0),
        .ready_i(ready1),
        .valid_o(valid1),
        .data_o (dout1),
        .cnt_o  (cnt1),
        .busy_o (busy1),
        .done_o (done1)
`ifdef REG_DRAIN_PARITY_EN
        ,
        .par_o  (par1)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: words pushed when a load is accepted, popped on each accepted beat.
    logic [W-1:0] exp_q[$];
    logic         exp_done = 1'b0;
    bit           mon_on   = 1'b0;
    int           beat_cnt = 0;

    always @(negedge clk) begin
        logic [W-1:0] front;
        if (mon_on) begin
            front = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("valid_o", valid_o, exp_q.size() != 0);
            check("data_o", data_o, front);
            check("cnt_o", cnt_o, exp_q.size());
            check("busy_o", busy_o, exp_q.size() != 0);
            check("done_o", done_o, exp_done);
`ifdef REG_DRAIN_PARITY_EN
            check("par_o", par_o, (exp_q.size() != 0) & (^front));
`endif
            if (valid_o && ready_i) beat_cnt++;
            exp_done = 1'b0;
            if (!rst_i) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                if (flush_i) begin
                    exp_q.delete();
                end else if (ready_i) begin
                    void'(exp_q.pop_front());
                    exp_done = (exp_q.size() == 0);
                end
            end else if (load_i) begin
                for (int k = D - 1; k >= 0; k--) exp_q.push_back(data_i[k]);
            end
        end
    end

    localparam logic [D-1:0][W-1:0] PAT = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [D-1:0][W-1:0] NEW = {8'hAA, 8'hAB, 8'hAC, 8'hAD};

    initial begin
        logic [3:0] rdy_pat;
        rdy_pat = 4'b1001;

        // 1: reset held with load asserted
        rst_i  = 1'b0;
        load_i = 1'b1;
        data_i = PAT;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step(2);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_data", data_o, 0);
        rst_i  = 1'b1;
        load_i = 1'b0;
        step();

        // 2: full-speed drain
        load_i  = 1'b1;
        ready_i = 1'b1;
        step();
        load_i = 1'b0;
        step(6);

        // 3: stalls, exactly four beats
        beat_cnt = 0;
        load_i   = 1'b1;
        ready_i  = 1'b1;
        step();
        load_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ready_i = rdy_pat[3 - (i % 4)];
            step();
        end
        check("stall_beats", beat_cnt, 4);
        ready_i = 1'b0;
        step();

        // 4: load during drain ignored, load on done cycle accepted
        load_i  = 1'b1;
        ready_i = 1'b1;
        step();
        data_i = NEW;
        step(4);
        check("final_done", done_o, 1);
        check("final_busy", busy_o, 0);
        step();
        check("done_load_busy", busy_o, 1);
        check("done_load_data", data_o, 8'hAA);
        load_i = 1'b0;
        data_i = PAT;
        step(6);

        // 5: flush after two beats, then reset mid-drain
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        step(2);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_valid", valid_o, 0);
        check("flush_cnt", cnt_o, 0);
        step();
        check("flush_no_done", done_o, 0);
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        check("midrst_valid", valid_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_cnt", cnt_o, 0);
        check("midrst_busy", busy_o, 0);
        rst_i = 1'b1;
        step();

        // 6: DEPTH=1 instance
        load1  = 1'b1;
        data1  = 8'h5A;
        ready1 = 1'b1;
        step();
        load1 = 1'b0;
        check("d1_valid", valid1, 1);
        check("d1_data", dout1, 8'h5A);
        check("d1_cnt", cnt1, 1);
`ifdef REG_DRAIN_PARITY_EN
        check("d1_par5a", par1, 0);
`endif
        step();
        check("d1_done", done1, 1);
        check("d1_idle", valid1, 0);
        check("d1_zero", dout1, 0);
        step();
        check("d1_done_pulse", done1, 0);
        load1  = 1'b1;
        data1  = 8'h01;
        ready1 = 1'b0;
        step();
        load1 = 1'b0;
        check("d1_data01", dout1, 8'h01);
        check("d1_hold_busy", busy1, 1);
`ifdef REG_DRAIN_PARITY_EN
        check("d1_par01", par1, 1);
`endif
        ready1 = 1'b1;
        step(2);
        check("d1_end_busy", busy1, 0);

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
